// File: rtl/writeback_register_file.sv
// writeback_register_file: W-stage result select, 32-entry register file, saturating commit counter.
// Define RF_BYPASS_EN for same-cycle write-through from the W stage to both read ports.
`default_nettype none

module writeback_register_file #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned RF_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic [DATA_WIDTH-1:0]    i_ALUOutW,
  input  logic [DATA_WIDTH-1:0]    i_ReadDataW,
  input  logic [ADDRESS_WIDTH-1:0] i_PCPlus4W,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegW,
  input  logic                     i_RegWriteW,
  input  logic [1:0]               i_MemtoRegW,
  input  logic [RF_ADDR_WIDTH-1:0] i_A1,
  input  logic [RF_ADDR_WIDTH-1:0] i_A2,
  output logic [DATA_WIDTH-1:0]    o_RD1,
  output logic [DATA_WIDTH-1:0]    o_RD2,
  output logic [DATA_WIDTH-1:0]    o_ResultW,
  output logic                     o_WriteEnW,
  output logic [CNT_WIDTH-1:0]     o_CommitCount
);

  localparam int unsigned DEPTH = 2 ** RF_ADDR_WIDTH;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;
  localparam logic [1:0] SEL_BAD  = 2'b11;

  logic [DATA_WIDTH-1:0] pc_ext;
  logic [DATA_WIDTH-1:0] result;
  logic                  write_en;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];

  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  cnt_d;

  always_comb begin
    pc_ext                    = '0;
    pc_ext[ADDRESS_WIDTH-1:0] = i_PCPlus4W;
  end

  always_comb begin
    result = '0;
    case (i_MemtoRegW)
      SEL_ALU:  result = i_ALUOutW;
      SEL_LOAD: result = i_ReadDataW;
      SEL_LINK: result = pc_ext;
      default:  result = '0;
    endcase
  end

  assign write_en = i_RegWriteW && (i_WriteRegW != '0) && (i_MemtoRegW != SEL_BAD);

  assign o_ResultW  = result;
  assign o_WriteEnW = write_en;

  // Entry 0 is hardwired; every other entry is its own enabled register.
  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
      if (g == 0) begin : g_zero
        assign regs_q[g] = '0;
      end else begin : g_reg
        logic wr_sel;
        assign wr_sel = write_en && (i_WriteRegW == RF_ADDR_WIDTH'(g));
        always_ff @(posedge i_CLK or negedge i_RST) begin
          if (!i_RST) begin
            regs_q[g] <= '0;
          end else if (wr_sel) begin
            regs_q[g] <= result;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    o_RD1 = '0;
    if (i_A1 != '0) begin
      o_RD1 = regs_q[i_A1];
    end
`ifdef RF_BYPASS_EN
    if (write_en && (i_A1 == i_WriteRegW)) begin
      o_RD1 = result;
    end
`endif
  end

  always_comb begin
    o_RD2 = '0;
    if (i_A2 != '0) begin
      o_RD2 = regs_q[i_A2];
    end
`ifdef RF_BYPASS_EN
    if (write_en && (i_A2 == i_WriteRegW)) begin
      o_RD2 = result;
    end
`endif
  end

  // Counter holds at all-ones rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (write_en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_CommitCount = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_writeback_register_file.sv
// Directed bench for writeback_register_file; a second instance with a 4-bit counter checks saturation.
`default_nettype none

module tb_writeback_register_file;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_out;
  logic [31:0] read_data;
  logic [31:0] pc_plus4;
  logic [4:0]  write_reg;
  logic        reg_write;
  logic [1:0]  mem_to_reg;
  logic [4:0]  a1;
  logic [4:0]  a2;

  logic [31:0] rd1, rd2, result;
  logic        write_en;
  logic [31:0] count;

  logic [31:0] s_rd1, s_rd2, s_result;
  logic        s_write_en;
  logic [3:0]  s_count;

  int n_vec = 0;
  int n_err = 0;

  writeback_register_file dut (
    .i_CLK        (clk),
    .i_RST        (rst_n),
    .i_ALUOutW    (alu_out),
    .i_ReadDataW  (read_data),
    .i_PCPlus4W   (pc_plus4),
    .i_WriteRegW  (write_reg),
    .i_RegWriteW  (reg_write),
    .i_MemtoRegW  (mem_to_reg),
    .i_A1         (a1),
    .i_A2         (a2),
    .o_RD1        (rd1),
    .o_RD2        (rd2),
    .o_ResultW    (result),
    .o_WriteEnW   (write_en),
    .o_CommitCount(count)
  );

  writeback_register_file #(.CNT_WIDTH(4)) dut_sat (
    .i_CLK        (clk),
    .i_RST        (rst_n),
    .i_ALUOutW    (alu_out),
    .i_ReadDataW  (read_data),
    .i_PCPlus4W   (pc_plus4),
    .i_WriteRegW  (write_reg),
    .i_RegWriteW  (reg_write),
    .i_MemtoRegW  (mem_to_reg),
    .i_A1         (a1),
    .i_A2         (a2),
    .o_RD1        (s_rd1),
    .o_RD2        (s_rd2),
    .o_ResultW    (s_result),
    .o_WriteEnW   (s_write_en),
    .o_CommitCount(s_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and checks happen mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic [4:0] wr, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc);
    reg_write  = rw;
    write_reg  = wr;
    mem_to_reg = sel;
    alu_out    = alu;
    read_data  = ld;
    pc_plus4   = pc;
  endtask

  logic [31:0] exp_byp;

  initial begin
    rst_n = 1'b0;
    a1 = 5'd0;
    a2 = 5'd0;
    drive(1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0);
    #2;
    chk("reset_count", count, 32'd0);
    chk("reset_rd1", rd1, 32'd0);

    step();
    rst_n = 1'b1;

    // Preload reg5 then hit it with an asynchronous reset mid-cycle.
    a1 = 5'd5;
    drive(1'b1, 5'd5, 2'b00, 32'hDEADBEEF, 32'h0, 32'h0);
    step();
    chk("preload_rd1", rd1, 32'hDEADBEEF);
    chk("preload_count", count, 32'd1);
    reg_write = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rd1", rd1, 32'd0);
    chk("async_rst_count", count, 32'd0);
    chk("async_rst_satcnt", {28'd0, s_count}, 32'd0);
    #1;
    rst_n = 1'b1;

    // Result mux into regs 8, 9, 31.
    drive(1'b1, 5'd8, 2'b00, 32'h11, 32'h22, 32'h400);
    #1;
    chk("mux_alu_result", result, 32'h11);
    chk("mux_alu_we", {31'd0, write_en}, 32'd1);
    step();
    drive(1'b1, 5'd9, 2'b01, 32'h11, 32'h22, 32'h400);
    #1;
    chk("mux_load_result", result, 32'h22);
    step();
    drive(1'b1, 5'd31, 2'b10, 32'h11, 32'h22, 32'h400);
    #1;
    chk("mux_link_result", result, 32'h400);
    step();
    reg_write = 1'b0;
    a1 = 5'd8;
    a2 = 5'd9;
    #1;
    chk("rd_reg8", rd1, 32'h11);
    chk("rd_reg9", rd2, 32'h22);
    a1 = 5'd31;
    #1;
    chk("rd_reg31", rd1, 32'h400);
    chk("count_after_mux", count, 32'd3);

    // Writes to register 0 are dropped.
    drive(1'b1, 5'd0, 2'b00, 32'hFFFFFFFF, 32'h0, 32'h0);
    a1 = 5'd0;
    a2 = 5'd0;
    #1;
    chk("r0_we", {31'd0, write_en}, 32'd0);
    chk("r0_result", result, 32'hFFFFFFFF);
    step();
    chk("r0_rd1", rd1, 32'd0);
    chk("r0_rd2", rd2, 32'd0);
    chk("r0_count", count, 32'd3);

    // Preload reg4, then an illegal select must not touch it.
    drive(1'b1, 5'd4, 2'b01, 32'h0, 32'h55, 32'h0);
    step();
    drive(1'b1, 5'd4, 2'b11, 32'h77, 32'h88, 32'h99);
    a1 = 5'd4;
    #1;
    chk("illegal_result", result, 32'd0);
    chk("illegal_we", {31'd0, write_en}, 32'd0);
    step();
    chk("illegal_reg4", rd1, 32'h55);
    chk("illegal_count", count, 32'd4);

    // Same-cycle write and read of reg10.
    drive(1'b1, 5'd10, 2'b00, 32'hAAAA, 32'h0, 32'h0);
    step();
    drive(1'b1, 5'd10, 2'b00, 32'h1234, 32'h0, 32'h0);
    a1 = 5'd10;
    a2 = 5'd10;
    #1;
`ifdef RF_BYPASS_EN
    exp_byp = 32'h1234;
`else
    exp_byp = 32'hAAAA;
`endif
    chk("bypass_rd1_pre", rd1, exp_byp);
    chk("bypass_rd2_pre", rd2, exp_byp);
    step();
    reg_write = 1'b0;
    #1;
    chk("bypass_rd1_post", rd1, 32'h1234);
    chk("bypass_rd2_post", rd2, 32'h1234);
    chk("bypass_count", count, 32'd6);
    chk("sat_count_6", {28'd0, s_count}, 32'd6);

    // Eleven more writes: 17 in total since reset, small counter pins at 0xF.
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, 5'(12 + i), 2'b00, 32'(i * 3 + 7), 32'h0, 32'h0);
      a1 = 5'(12 + i);
      step();
      chk("loop_rd1", rd1, 32'(i * 3 + 7));
      chk("sat_count", {28'd0, s_count}, (7 + i > 15) ? 32'd15 : 32'(7 + i));
    end
    reg_write = 1'b0;
    chk("main_count_17", count, 32'd17);
    step();
    chk("sat_hold", {28'd0, s_count}, 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/writeback_register_file.md
# writeback_register_file

Write-back stage and architectural register file of the pipelined MIPS core. Consumes the memory-to-write-back pipeline register outputs, selects the result (ALU output, load data, or PC+4 for link), and commits it to a 32-entry register file. Provides the two combinational read ports used by decode, plus a saturating commit counter for debug and performance monitoring.

## Interface
Parameters:
- DATA_WIDTH, 32, register and result width
- ADDRESS_WIDTH, 32, width of PC+4 input; must be ≤ DATA_WIDTH, zero-extended into result
- RF_ADDR_WIDTH, 5, register index width; depth = 2**RF_ADDR_WIDTH
- CNT_WIDTH, 32, commit counter width

Ports:
- i_CLK  in  1  clock, all state updates on rising edge
- i_RST  in  1  asynchronous, active-low reset
- i_ALUOutW  in  DATA_WIDTH  ALU result from W stage
- i_ReadDataW  in  DATA_WIDTH  load data from W stage
- i_PCPlus4W  in  ADDRESS_WIDTH  link address from W stage
- i_WriteRegW  in  RF_ADDR_WIDTH  destination register index
- i_RegWriteW  in  1  write request
- i_MemtoRegW  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 illegal
- i_A1, i_A2  in  RF_ADDR_WIDTH  decode read addresses
- o_RD1, o_RD2  out  DATA_WIDTH  read data, combinational
- o_ResultW  out  DATA_WIDTH  selected result, combinational, to hazard/forwarding unit
- o_WriteEnW  out  1  qualified write enable, combinational
- o_CommitCount  out  CNT_WIDTH  number of committed writes, registered

## Operation
- Result mux: 00 → i_ALUOutW; 01 → i_ReadDataW; 10 → zero-extended i_PCPlus4W; 11 → 0.
- Qualified write: o_WriteEnW = i_RegWriteW & (i_WriteRegW != 0) & (i_MemtoRegW != 11).
- On rising edge with o_WriteEnW=1: reg[i_WriteRegW] ← o_ResultW. Otherwise no state change to the array.
- Register 0: never written, always reads 0 regardless of any input.
- Reads: o_RDn = 0 if i_An == 0; else array contents (subject to bypass, see Configuration).
- Commit counter: increments by 1 on each edge with o_WriteEnW=1; saturates at all-ones (no wrap). Writes to register 0 and illegal-select cycles do not count.

## Timing
- Reset (i_RST=0, asynchronous, any time): all array entries → 0, o_CommitCount → 0 immediately; held while low. Combinational outputs follow inputs and reset-zeroed array (o_RD1/o_RD2 = 0 without bypass hit).
- Reset deassertion: first write may occur on the first rising edge with i_RST=1.
- Write latency: value visible in array one edge after presentation; o_CommitCount updates on the same edge.
- o_ResultW, o_WriteEnW: zero-cycle combinational from W inputs.
- Simultaneous write and read of same nonzero index: result per Configuration.
- Simultaneous reads of same index on both ports: both return identical data.
- Reset asserted in the same cycle as a write: reset wins, write lost, counter 0.

## Configuration
- RF_BYPASS_EN defined: when o_WriteEnW=1 and i_An == i_WriteRegW (nonzero), o_RDn = o_ResultW in the same cycle (write-through), removing the W→D hazard.
- RF_BYPASS_EN undefined: o_RDn always returns the stored array value; a same-cycle write is seen one cycle later, and the hazard unit must stall or forward for that case.

## Test plan
- Reset: preload reg5=0xDEADBEEF, assert i_RST=0 mid-cycle → o_RD1 (A1=5)=0 and o_CommitCount=0 before next edge.
- Mux/write: RegWrite=1, WriteReg=8, MemtoReg=00/01/10 with ALUOut=0x11, ReadData=0x22, PCPlus4=0x400 on three edges to regs 8,9,31 → reads 0x11, 0x22, 0x400; count=3.
- Register 0: RegWrite=1, WriteReg=0, ALUOut=0xFFFFFFFF → o_RD1 (A1=0)=0, o_WriteEnW=0, count unchanged.
- Illegal select: MemtoReg=11, WriteReg=4 → o_ResultW=0, reg4 unchanged, count unchanged.
- Bypass: write 0x1234 to reg10 with A1=A2=10 in same cycle → with RF_BYPASS_EN both read 0x1234 before the edge; without it, old value before the edge, 0x1234 after.
- Saturation: CNT_WIDTH=4, 17 qualified writes → o_CommitCount stops at 0xF.
